// File: rtl/islip_sched_param_if.sv
// ============================================================================
// Module  : islip_sched_param_if
// Brief   : Request/match handshake bundle between VOQ logic and the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface islip_sched_param_if #(
    parameter int NPORT = 4
);
    logic                     arb_valid_in;
    logic                     arb_ready_in;
    logic [NPORT*NPORT-1:0]   rx_req_vect;
    logic [NPORT-1:0]         tx_rdy_vect;
    logic                     arb_valid_out;
    logic                     arb_ready_out;
    logic [NPORT*NPORT-1:0]   arb_vect;

    modport master (
        output arb_valid_in, rx_req_vect, tx_rdy_vect, arb_ready_out,
        input  arb_ready_in, arb_valid_out, arb_vect
    );

    modport slave (
        input  arb_valid_in, rx_req_vect, tx_rdy_vect, arb_ready_out,
        output arb_ready_in, arb_valid_out, arb_vect
    );
endinterface

`default_nettype wire

// File: rtl/islip_sched_param.sv
// ============================================================================
// Module  : islip_sched_param
// Brief   : NPORT x NPORT iSLIP scheduler, up to ITER grant/accept iterations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module islip_sched_param #(
    parameter int NPORT = 4,
    parameter int ITER  = 2,
    parameter int PW    = $clog2(NPORT)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    islip_sched_param_if.slave  arb
);
    localparam int C_NN = NPORT * NPORT;
    localparam int C_IW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GRNT = 2'd1,
        ACPT = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [C_NN-1:0]   r_req, r_match, r_grant;
    logic [C_NN-1:0]   w_grant, w_accept;
    logic [PW-1:0]     r_gptr [NPORT];
    logic [PW-1:0]     r_aptr [NPORT];
    logic [C_IW-1:0]   r_iter;
    logic              r_ready_in, r_valid_out;
    logic [NPORT-1:0]  w_row_m, w_col_m;
    logic              w_any_accept, w_last_iter, w_hshake;

    // (p + k) mod NPORT for p, k < NPORT, without a divider
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(k);
        if (s >= (PW+1)'(NPORT))
            s = s - (PW+1)'(NPORT);
        return s[PW-1:0];
    endfunction

    genvar g;
    generate
        for (g = 0; g < NPORT; g++) begin : g_row_matched
            assign w_row_m[g] = |r_match[g*NPORT +: NPORT];
        end
    endgenerate

    always_comb begin
        w_col_m = '0;
        for (int i = 0; i < NPORT; i++)
            for (int j = 0; j < NPORT; j++)
                if (r_match[i*NPORT+j])
                    w_col_m[j] = 1'b1;
    end

    // Each free output picks the first free requesting input at or after its pointer
    always_comb begin
        logic [NPORT-1:0] found;
        found   = '0;
        w_grant = '0;
        for (int j = 0; j < NPORT; j++)
            for (int k = 0; k < NPORT; k++)
                for (int i = 0; i < NPORT; i++)
                    if (!found[j] && !w_col_m[j] && !w_row_m[i] && r_req[i*NPORT+j] &&
                        wrap_add(r_gptr[j], k) == PW'(i)) begin
                        w_grant[i*NPORT+j] = 1'b1;
                        found[j]           = 1'b1;
                    end
    end

    always_comb begin
        logic [NPORT-1:0] found;
        found    = '0;
        w_accept = '0;
        for (int i = 0; i < NPORT; i++)
            for (int k = 0; k < NPORT; k++)
                for (int j = 0; j < NPORT; j++)
                    if (!found[i] && !w_row_m[i] && r_grant[i*NPORT+j] &&
                        wrap_add(r_aptr[i], k) == PW'(j)) begin
                        w_accept[i*NPORT+j] = 1'b1;
                        found[i]            = 1'b1;
                    end
    end

    assign w_any_accept = |w_accept;
    assign w_last_iter  = (r_iter == C_IW'(ITER));
    assign w_hshake     = arb.arb_valid_in && r_ready_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hshake) w_state_nxt = GRNT;
            GRNT:    w_state_nxt = ACPT;
            ACPT:    w_state_nxt = (!w_any_accept || w_last_iter) ? WAIT : GRNT;
            WAIT:    if (arb.arb_ready_out) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req       <= '0;
            r_match     <= '0;
            r_grant     <= '0;
            r_iter      <= '0;
            r_ready_in  <= 1'b0;
            r_valid_out <= 1'b0;
            for (int n = 0; n < NPORT; n++) begin
                r_gptr[n] <= '0;
                r_aptr[n] <= '0;
            end
        end else begin
            r_ready_in  <= (w_state_nxt == IDLE);
            r_valid_out <= (w_state_nxt == WAIT);
            case (r_state)
                IDLE: if (w_hshake) begin
                    r_req   <= arb.rx_req_vect & {NPORT{arb.tx_rdy_vect}};
                    r_match <= '0;
                    r_iter  <= C_IW'(1);
                end
                GRNT: r_grant <= w_grant;
                ACPT: begin
                    r_match <= r_match | w_accept;
                    if (w_any_accept && !w_last_iter)
                        r_iter <= r_iter + C_IW'(1);
                    // Pointers only slip on first-iteration matches to preserve fairness
                    if (r_iter == C_IW'(1))
                        for (int i = 0; i < NPORT; i++)
                            for (int j = 0; j < NPORT; j++)
                                if (w_accept[i*NPORT+j]) begin
                                    r_gptr[j] <= wrap_add(PW'(i), 1);
                                    r_aptr[i] <= wrap_add(PW'(j), 1);
                                end
                end
                default: ;
            endcase
        end
    end

    assign arb.arb_ready_in  = r_ready_in;
    assign arb.arb_valid_out = r_valid_out;
    assign arb.arb_vect      = r_match;

endmodule

`default_nettype wire

// File: tb/tb_islip_sched_param.sv
// ============================================================================
// Module  : tb_islip_sched_param
// Brief   : Directed self-checking bench for the 4x4, 2-iteration scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_islip_sched_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] sb_req = '0;
    int   lat;

    always #5 clk = ~clk;

    islip_sched_param_if #(.NPORT(4)) bus ();

    islip_sched_param #(.NPORT(4), .ITER(2)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // At most one bit per row and column, and only where the captured request was set
    task automatic check_inv();
        logic ok;
        int   cnt;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            for (int j = 0; j < 4; j++) cnt += int'(bus.arb_vect[i*4+j]);
            if (cnt > 1) ok = 1'b0;
        end
        for (int j = 0; j < 4; j++) begin
            cnt = 0;
            for (int i = 0; i < 4; i++) cnt += int'(bus.arb_vect[i*4+j]);
            if (cnt > 1) ok = 1'b0;
        end
        if ((bus.arb_vect & ~sb_req) != 16'h0) ok = 1'b0;
        chk("invariant", 32'(ok), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.arb_valid_out) check_inv();
    endtask

    // Handshake, then scramble inputs and count edges until the match is presented
    task automatic run_round(input logic [15:0] req, input logic [3:0] rdy, output int n);
        int w;
        w = 0;
        while (!bus.arb_ready_in && w < 20) begin step(); w++; end
        chk("ready_before_round", 32'(bus.arb_ready_in), 32'd1);
        bus.rx_req_vect  = req;
        bus.tx_rdy_vect  = rdy;
        bus.arb_valid_in = 1'b1;
        sb_req = req & {4{rdy}};
        step();
        bus.arb_valid_in = 1'b0;
        bus.rx_req_vect  = 16'hFFFF;
        bus.tx_rdy_vect  = 4'hF;
        n = 0;
        while (!bus.arb_valid_out && n < 40) begin step(); n++; end
    endtask

    task automatic release_round();
        bus.arb_ready_out = 1'b1;
        step();
        bus.arb_ready_out = 1'b0;
        chk("valid_after_release", 32'(bus.arb_valid_out), 32'd0);
        chk("ready_after_release", 32'(bus.arb_ready_in), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        bus.arb_valid_in  = 1'b0;
        bus.arb_ready_out = 1'b0;
        bus.rx_req_vect   = '0;
        bus.tx_rdy_vect   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(bus.arb_valid_out), 32'd0);
        chk("rst_ready_in",  32'(bus.arb_ready_in),  32'd0);
        chk("rst_arb_vect",  32'(bus.arb_vect),      32'd0);
        rst = 1'b0;
        step();
        chk("ready_first_edge", 32'(bus.arb_ready_in), 32'd1);

        // 1: in0->out1, in1->out2, second iteration adds nothing
        run_round(16'h00C2, 4'hF, lat);
        chk("t1_latency", 32'(lat), 32'd4);
        chk("t1_vect", 32'(bus.arb_vect), 32'h0042);
        chk("t1_gptr1", 32'(dut.r_gptr[1]), 32'd1);
        chk("t1_gptr2", 32'(dut.r_gptr[2]), 32'd2);
        chk("t1_aptr0", 32'(dut.r_aptr[0]), 32'd2);
        chk("t1_aptr1", 32'(dut.r_aptr[1]), 32'd3);
        release_round();

        // 2: everyone wants out0; round-robin winner in0..in3
        for (int r = 0; r < 4; r++) begin
            run_round(16'h1111, 4'hF, lat);
            chk("t2_latency", 32'(lat), 32'd4);
            chk("t2_vect", 32'(bus.arb_vect), 32'(16'h0001 << (4 * r)));
            release_round();
        end
        chk("t2_gptr0_wrap", 32'(dut.r_gptr[0]), 32'd0);

        // 3: full requests, only out0/out2 ready
        do_reset();
        run_round(16'hFFFF, 4'h5, lat);
        chk("t3_latency", 32'(lat), 32'd4);
        chk("t3_vect", 32'(bus.arb_vect), 32'h0041);
        chk("t3_gptr2", 32'(dut.r_gptr[2]), 32'd0);
        chk("t3_gptr0", 32'(dut.r_gptr[0]), 32'd1);
        release_round();

        // 4: no requests, then no ready outputs
        run_round(16'h0000, 4'hF, lat);
        chk("t4_latency", 32'(lat), 32'd2);
        chk("t4_vect", 32'(bus.arb_vect), 32'd0);
        chk("t4_gptr0", 32'(dut.r_gptr[0]), 32'd1);
        chk("t4_aptr0", 32'(dut.r_aptr[0]), 32'd1);
        release_round();
        run_round(16'hFFFF, 4'h0, lat);
        chk("t4b_latency", 32'(lat), 32'd2);
        chk("t4b_vect", 32'(bus.arb_vect), 32'd0);
        release_round();

        // 5: downstream stalls in WAIT while inputs churn
        run_round(16'h0800, 4'hF, lat);
        chk("t5_latency", 32'(lat), 32'd4);
        for (int c = 0; c < 5; c++) begin
            bus.arb_valid_in = c[0];
            bus.rx_req_vect  = 16'($urandom);
            step();
            chk("t5_hold_valid", 32'(bus.arb_valid_out), 32'd1);
            chk("t5_hold_vect",  32'(bus.arb_vect),      32'h0800);
            chk("t5_hold_ready", 32'(bus.arb_ready_in),  32'd0);
        end
        bus.arb_valid_in = 1'b0;
        release_round();
        chk("t5_gptr3", 32'(dut.r_gptr[3]), 32'd3);
        chk("t5_aptr2_wrap", 32'(dut.r_aptr[2]), 32'd0);

        // 6: reset lands during the first ACPT cycle
        bus.rx_req_vect  = 16'h00C2;
        bus.tx_rdy_vect  = 4'hF;
        bus.arb_valid_in = 1'b1;
        sb_req = 16'h00C2;
        step();
        bus.arb_valid_in = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("t6_valid_out", 32'(bus.arb_valid_out), 32'd0);
        chk("t6_ready_in",  32'(bus.arb_ready_in),  32'd0);
        chk("t6_vect",      32'(bus.arb_vect),      32'd0);
        step();
        rst = 1'b0;
        chk("t6_gptr3", 32'(dut.r_gptr[3]), 32'd0);
        chk("t6_gptr1", 32'(dut.r_gptr[1]), 32'd0);
        chk("t6_aptr0", 32'(dut.r_aptr[0]), 32'd0);
        chk("t6_ready_held", 32'(bus.arb_ready_in), 32'd0);
        step();
        chk("t6_ready_release", 32'(bus.arb_ready_in), 32'd1);
        chk("t6_valid_release", 32'(bus.arb_valid_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
